// File: rtl/fb_scanout.sv
// fb_scanout: 1bpp framebuffer scanout engine. Fetches the frame one 1024-bit
// memory line at a time and serialises it in raster order onto a pixel stream.
// Optional macro FB_SCANOUT_PREFETCH_EN: ping-pong line buffers, with the next
// line prefetched while the current one streams out.
// Handshakes: a transfer happens on a rising clk edge where valid && ready;
// valid, once raised, and its payload hold until that transfer (mem_rsp_valid
// is a single-cycle strobe with no ready).
module fb_scanout #(
  parameter int          FB_WIDTH  = 64,
  parameter int          FB_HEIGHT = 64,
  parameter logic [31:0] FB_BASE   = 32'h2000,
  parameter int          LINE_BITS = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [31:0]          mem_req_addr,
  input  logic                 mem_rsp_valid,
  input  logic [LINE_BITS-1:0] mem_rsp_data,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output logic                 pix_data,
  output logic [15:0]          pix_x,
  output logic [15:0]          pix_y,
  output logic                 pix_sof,
  output logic                 pix_eol,
  output logic                 pix_eof
);
  localparam int LINES = FB_WIDTH * FB_HEIGHT / LINE_BITS;
  localparam int KW    = (LINES > 1) ? $clog2(LINES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_STREAM, S_DONE} state_t;
  state_t state, state_nxt;

  logic [KW-1:0]        k;         // line currently streaming
  logic [9:0]           idx;       // bit index of the pixel held in the output regs
  logic [15:0]          nx, ny;    // coordinates of the next pixel to be loaded
  logic [LINE_BITS-1:0] buf0;
  logic                 hs, line_end, last_line, load, load_bit, cur_bit;

  assign hs        = pix_valid && pix_ready;
  assign line_end  = (state == S_STREAM) && hs && (idx == 10'd1023);
  assign last_line = (32'(k) == 32'(LINES - 1));

`ifdef FB_SCANOUT_PREFETCH_EN
  logic [LINE_BITS-1:0] buf1;
  logic cur, pf_req, pf_wait, pf_have, pf_stall;
  logic rsp_in, next_rdy, swap, more_lines, next_bit0;

  assign rsp_in     = (state == S_STREAM) && pf_wait && mem_rsp_valid;
  assign next_rdy   = pf_have || rsp_in;
  // Swap to the next line at the line boundary, or when a late line arrives.
  assign swap       = (line_end && !last_line && next_rdy) || (pf_stall && rsp_in);
  // Is there a line beyond the one being swapped in?
  assign more_lines = (32'(k) + 32'd2) < 32'(LINES);
  assign cur_bit    = cur ? buf1[idx + 10'd1] : buf0[idx + 10'd1];
  assign next_bit0  = pf_have ? (cur ? buf0[0] : buf1[0]) : mem_rsp_data[0];
`else
  assign cur_bit    = buf0[idx + 10'd1];
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nxt     = state;
    busy          = (state != S_IDLE);
    frame_done    = (state == S_DONE);
`ifdef FB_SCANOUT_PREFETCH_EN
    mem_req_valid = (state == S_REQ) || pf_req;
`else
    mem_req_valid = (state == S_REQ);
`endif
    case (state)
      S_IDLE:   if (start) state_nxt = S_REQ;
      S_REQ:    if (mem_req_ready) state_nxt = S_WAIT;
      S_WAIT:   if (mem_rsp_valid) state_nxt = S_STREAM;
      S_STREAM: begin
        if (line_end) begin
          if (last_line) state_nxt = S_DONE;
`ifndef FB_SCANOUT_PREFETCH_EN
          else           state_nxt = S_REQ;
`endif
        end
      end
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Select when a new pixel enters the output regs and where its bit comes from.
  always_comb begin
    load     = 1'b0;
    load_bit = 1'b0;
    if (state == S_WAIT && mem_rsp_valid) begin
      load     = 1'b1;
      load_bit = mem_rsp_data[0];
    end else if (state == S_STREAM && hs && idx != 10'd1023) begin
      load     = 1'b1;
      load_bit = cur_bit;
    end
`ifdef FB_SCANOUT_PREFETCH_EN
    else if (swap) begin
      load     = 1'b1;
      load_bit = next_bit0;
    end
`endif
  end

  // Line sequencing: line index, bit index, request address, prefetch flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k            <= '0;
      idx          <= '0;
      mem_req_addr <= FB_BASE;
`ifdef FB_SCANOUT_PREFETCH_EN
      cur <= 1'b0; pf_req <= 1'b0; pf_wait <= 1'b0; pf_have <= 1'b0; pf_stall <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (start) begin
          k            <= '0;
          idx          <= '0;
          mem_req_addr <= FB_BASE;
`ifdef FB_SCANOUT_PREFETCH_EN
          cur <= 1'b0; pf_req <= 1'b0; pf_wait <= 1'b0; pf_have <= 1'b0; pf_stall <= 1'b0;
`endif
        end
        S_WAIT: if (mem_rsp_valid) begin
          idx <= '0;
`ifdef FB_SCANOUT_PREFETCH_EN
          if (LINES > 1) begin
            pf_req       <= 1'b1;
            mem_req_addr <= mem_req_addr + 32'd128;
          end
`endif
        end
        S_STREAM: begin
          if (hs && idx != 10'd1023) idx <= idx + 10'd1;
`ifdef FB_SCANOUT_PREFETCH_EN
          if (pf_req && mem_req_ready) begin
            pf_req  <= 1'b0;
            pf_wait <= 1'b1;
          end
          if (rsp_in) begin
            pf_wait <= 1'b0;
            pf_have <= 1'b1;
          end
          if (line_end && !last_line && !next_rdy) pf_stall <= 1'b1;
          if (swap) begin
            cur      <= ~cur;
            k        <= k + 1'b1;
            idx      <= '0;
            pf_have  <= 1'b0;
            pf_stall <= 1'b0;
            if (more_lines) begin
              pf_req       <= 1'b1;
              mem_req_addr <= mem_req_addr + 32'd128;
            end
          end
`else
          if (line_end && !last_line) begin
            k            <= k + 1'b1;
            mem_req_addr <= mem_req_addr + 32'd128;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  // Line buffer capture (data only, no reset needed).
  always_ff @(posedge clk) begin
    if (state == S_WAIT && mem_rsp_valid) buf0 <= mem_rsp_data;
`ifdef FB_SCANOUT_PREFETCH_EN
    else if (rsp_in) begin
      if (cur) buf0 <= mem_rsp_data;
      else     buf1 <= mem_rsp_data;
    end
`endif
  end

  // Pixel output registers; they hold while valid && !ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_valid <= 1'b0; pix_data <= 1'b0; pix_x <= '0; pix_y <= '0;
      pix_sof <= 1'b0; pix_eol <= 1'b0; pix_eof <= 1'b0;
      nx <= '0; ny <= '0;
    end else begin
      if (state == S_IDLE) begin
        nx <= '0;
        ny <= '0;
      end
      if (load) begin
        pix_valid <= 1'b1;
        pix_data  <= load_bit;
        pix_x     <= nx;
        pix_y     <= ny;
        pix_sof   <= (nx == 16'd0) && (ny == 16'd0);
        pix_eol   <= (nx == 16'(FB_WIDTH - 1));
        pix_eof   <= (nx == 16'(FB_WIDTH - 1)) && (ny == 16'(FB_HEIGHT - 1));
        if (nx == 16'(FB_WIDTH - 1)) begin
          nx <= '0;
          ny <= ny + 16'd1;
        end else begin
          nx <= nx + 16'd1;
        end
      end else if (hs) begin
        pix_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fb_scanout.sv
// Testbench for fb_scanout: memory responder, stream monitor and a raster
// reference model computed from byte/bit addressing of the framebuffer.
module tb_fb_scanout;
  localparam int W  = 64;
  localparam int H  = 64;
  localparam int NB = W * H / 8;
  localparam int NPIX = W * H;

  logic clk, rst_n, start, busy, frame_done;
  logic mem_req_valid, mem_req_ready, mem_rsp_valid;
  logic [31:0] mem_req_addr;
  logic [1023:0] mem_rsp_data;
  logic pix_valid, pix_ready, pix_data, pix_sof, pix_eol, pix_eof;
  logic [15:0] pix_x, pix_y;

  fb_scanout dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .frame_done(frame_done),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_x(pix_x), .pix_y(pix_y), .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof)
  );

  // Clock and scoreboard state.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  logic [7:0]  fb [0:NB-1];
  logic [35:0] exp_q[$];
  logic [35:0] got_q[$];
  int hs_cyc[$], req_rise_q[$];
  logic [31:0] addr_q[$];
  int cyc = 0, done_cnt = 0, last_done_cyc = 0, stall_viol = 0, outst_viol = 0;
  int start_cyc = 0, mem_lat = 3, inject_req = 0;
  bit rand_pix = 0, rand_mem = 0;

  // Ready drivers, changed just after the rising edge.
  initial begin
    pix_ready = 1'b1; mem_req_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      pix_ready     = rand_pix ? 1'($urandom_range(0, 1)) : 1'b1;
      mem_req_ready = rand_mem ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Memory: single outstanding read, response mem_lat cycles after acceptance.
  initial begin
    bit pending; int cnt, inject_seen; logic [31:0] pend_addr;
    pending = 0; cnt = 0; inject_seen = 0; pend_addr = '0;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    forever begin
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      if (!rst_n) pending = 0;
      else begin
        if (pending) begin
          cnt--;
          if (cnt == 0) begin
            for (int b = 0; b < 128; b++) mem_rsp_data[b*8 +: 8] = fb[int'(pend_addr - 32'h2000) + b];
            mem_rsp_valid = 1'b1;
            pending = 0;
          end
        end
        if (mem_req_valid && mem_req_ready) begin
          if (pending) outst_viol++;
          pending = 1;
          cnt = rand_mem ? $urandom_range(1, 6) : mem_lat;
          pend_addr = mem_req_addr;
          addr_q.push_back(mem_req_addr);
        end
      end
      if (inject_req != inject_seen) begin
        inject_seen = inject_req;
        mem_rsp_valid = 1'b1;
        for (int b = 0; b < 32; b++) mem_rsp_data[b*32 +: 32] = $urandom;
      end
    end
  end

  // Monitor: records handshakes, stall stability, frame_done and request rises.
  initial begin
    bit prev_stall, prev_req; logic [35:0] prev_v, cur_v;
    prev_stall = 0; prev_req = 0; prev_v = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_stall = 0; prev_req = 0;
      end else begin
        cur_v = {pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof};
        if (prev_stall && (pix_valid !== 1'b1 || cur_v !== prev_v)) stall_viol++;
        prev_stall = pix_valid && !pix_ready;
        prev_v = cur_v;
        if (pix_valid && pix_ready) begin
          got_q.push_back(cur_v);
          hs_cyc.push_back(cyc);
        end
        if (frame_done) begin
          done_cnt++;
          last_done_cyc = cyc;
        end
        if (mem_req_valid && !prev_req) req_rise_q.push_back(cyc);
        prev_req = mem_req_valid;
      end
    end
  end

  // Reference model: raster order straight from byte/bit addressing.
  task automatic build_model();
    int x, y; logic [7:0] byt;
    exp_q.delete();
    for (int p = 0; p < NPIX; p++) begin
      x = p % W; y = p / W;
      byt = fb[y * (W / 8) + x / 8];
      exp_q.push_back({byt[x % 8], 16'(x), 16'(y), 1'(p == 0), 1'(x == W - 1), 1'(p == NPIX - 1)});
    end
  endtask

  task automatic fill_fb(input int mode); // 0 zero, 1 ones, 2 random
    for (int i = 0; i < NB; i++) fb[i] = (mode == 0) ? 8'h00 : (mode == 1) ? 8'hFF : 8'($urandom);
  endtask

  function automatic int stream_mis(input int g);
    int n = 0;
    if (got_q.size() < g + NPIX) return NPIX;
    for (int i = 0; i < NPIX; i++) if (got_q[g + i] !== exp_q[i]) n++;
    return n;
  endfunction

  task automatic pulse_start();
    @(posedge clk); #1; start = 1'b1; start_cyc = cyc + 1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (frame_done) begin ok = 1; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input int budget, output bit ok);
    pulse_start();
    wait_done(budget, ok);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, frame_done, mem_req_valid, pix_valid, pix_data, pix_sof, pix_eol, pix_eof} !== 8'h00) begin
      failures++; $display("FAIL reset_flags got=%b exp=00000000",
        {busy, frame_done, mem_req_valid, pix_valid, pix_data, pix_sof, pix_eol, pix_eof});
    end
    checks++;
    if (mem_req_addr !== 32'h2000) begin failures++; $display("FAIL reset_addr got=%h exp=00002000", mem_req_addr); end
    checks++;
    if ({pix_x, pix_y} !== 32'h0) begin failures++; $display("FAIL reset_xy got=%0d,%0d exp=0,0", pix_x, pix_y); end
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_single_pixel();
    bit ok; int g0, a0, ones, pos; logic [35:0] v;
    fill_fb(0); fb[16'h2C] = 8'h20; build_model();
    mem_lat = 3; rand_pix = 0; rand_mem = 0;
    g0 = got_q.size(); a0 = addr_q.size();
    run_frame(20000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_timeout got=no_done exp=done"); end
    checks++;
    if (got_q.size() - g0 != NPIX) begin failures++; $display("FAIL single_count got=%0d exp=%0d", got_q.size() - g0, NPIX); end
    ones = 0; pos = -1; v = '0;
    for (int i = g0; i < got_q.size(); i++) if (got_q[i][35]) begin ones++; pos = i - g0; v = got_q[i]; end
    checks++; if (ones != 1) begin failures++; $display("FAIL single_ones got=%0d exp=1", ones); end
    checks++; if (pos != 357) begin failures++; $display("FAIL single_pos got=%0d exp=357", pos); end
    checks++;
    if (v[34:3] !== {16'd37, 16'd5}) begin failures++; $display("FAIL single_xy got=%0d,%0d exp=37,5", v[34:19], v[18:3]); end
    checks++;
    if (addr_q.size() - a0 != 4 || addr_q[a0] !== 32'h2000 || addr_q[a0+1] !== 32'h2080 ||
        addr_q[a0+2] !== 32'h2100 || addr_q[a0+3] !== 32'h2180) begin
      failures++; $display("FAIL single_addrs got_n=%0d first=%h exp=2000,2080,2100,2180", addr_q.size() - a0,
        (addr_q.size() > a0) ? addr_q[a0] : 32'h0);
    end
    checks++; if (stream_mis(g0) != 0) begin failures++; $display("FAIL single_stream got=%0d_mismatches exp=0", stream_mis(g0)); end
  endtask

  task automatic test_full_frame();
    bit ok; int g0, h0, d0, r0, sofs, eols, gap, min_gap, first_hs;
    fill_fb(1); build_model();
    mem_lat = 10; rand_pix = 0; rand_mem = 0;
    g0 = got_q.size(); h0 = hs_cyc.size(); d0 = done_cnt; r0 = req_rise_q.size();
    run_frame(20000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL full_timeout got=no_done exp=done"); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL full_busy_after got=%b exp=0", busy); end
    checks++; if (stream_mis(g0) != 0) begin failures++; $display("FAIL full_stream got=%0d_mismatches exp=0", stream_mis(g0)); end
    sofs = 0; eols = 0;
    for (int i = g0; i < got_q.size(); i++) begin sofs += int'(got_q[i][2]); eols += int'(got_q[i][1]); end
    checks++; if (sofs != 1 || eols != H) begin failures++; $display("FAIL full_markers got=sof%0d,eol%0d exp=sof1,eol%0d", sofs, eols, H); end
    checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL full_done_count got=%0d exp=1", done_cnt - d0); end
    if (hs_cyc.size() >= h0 + NPIX && req_rise_q.size() > r0) begin
      first_hs = hs_cyc[h0];
      checks++;
      if (last_done_cyc != hs_cyc[h0 + NPIX - 1] + 1) begin
        failures++; $display("FAIL full_done_timing got=%0d exp=%0d", last_done_cyc, hs_cyc[h0 + NPIX - 1] + 1);
      end
      checks++;
      if (req_rise_q[r0] != start_cyc + 1) begin failures++; $display("FAIL req_latency got=%0d exp=%0d", req_rise_q[r0], start_cyc + 1); end
      checks++;
      if (first_hs != start_cyc + 2 + mem_lat) begin failures++; $display("FAIL first_pix_latency got=%0d exp=%0d", first_hs, start_cyc + 2 + mem_lat); end
`ifdef FB_SCANOUT_PREFETCH_EN
      checks++;
      if (hs_cyc[h0 + NPIX - 1] - first_hs != NPIX - 1) begin
        failures++; $display("FAIL prefetch_span got=%0d exp=%0d", hs_cyc[h0 + NPIX - 1] - first_hs, NPIX - 1);
      end
`else
      min_gap = 1 << 30;
      for (int l = 1; l < NPIX / 1024; l++) begin
        gap = hs_cyc[h0 + l * 1024] - hs_cyc[h0 + l * 1024 - 1];
        if (gap < min_gap) min_gap = gap;
      end
      checks++; if (min_gap < 12) begin failures++; $display("FAIL line_gap got=%0d exp>=12", min_gap); end
`endif
    end else begin
      checks++; failures++; $display("FAIL full_timing got=missing_events exp=%0d_handshakes", NPIX);
    end
  endtask

  task automatic test_random_ready();
    bit ok; int g0, d0, s0, o0;
    fill_fb(2); build_model();
    rand_pix = 1; rand_mem = 1;
    g0 = got_q.size(); d0 = done_cnt; s0 = stall_viol; o0 = outst_viol;
    run_frame(40000, ok);
    rand_pix = 0; rand_mem = 0;
    checks++; if (!ok) begin failures++; $display("FAIL rand_timeout got=no_done exp=done"); end
    checks++; if (stream_mis(g0) != 0) begin failures++; $display("FAIL rand_stream got=%0d_mismatches exp=0", stream_mis(g0)); end
    checks++; if (stall_viol != s0) begin failures++; $display("FAIL rand_stall_hold got=%0d exp=0", stall_viol - s0); end
    checks++; if (outst_viol != o0) begin failures++; $display("FAIL rand_outstanding got=%0d exp=0", outst_viol - o0); end
    checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL rand_done_count got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    bit reached; int g0, pv;
    fill_fb(2); mem_lat = 3;
    g0 = got_q.size();
    pulse_start();
    reached = 0;
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      if (got_q.size() >= g0 + 1024 + 100) begin reached = 1; break; end
    end
    checks++; if (!reached) begin failures++; $display("FAIL midreset_reach got=%0d exp>=%0d", got_q.size() - g0, 1124); end
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, frame_done, mem_req_valid, pix_valid, pix_data, pix_sof, pix_eol, pix_eof} !== 8'h00 ||
        mem_req_addr !== 32'h2000 || {pix_x, pix_y} !== 32'h0) begin
      failures++; $display("FAIL midreset_values got=%b,%h,%0d,%0d exp=00000000,00002000,0,0",
        {busy, frame_done, mem_req_valid, pix_valid, pix_data, pix_sof, pix_eol, pix_eof}, mem_req_addr, pix_x, pix_y);
    end
    @(posedge clk); #1; @(posedge clk); #1;
    inject_req++;
    pv = 0;
    for (int n = 0; n < 12; n++) begin @(negedge clk); if (pix_valid || busy) pv++; end
    checks++; if (pv != 0) begin failures++; $display("FAIL stale_rsp got=%0d_active_cycles exp=0", pv); end
  endtask

  task automatic test_start_ignored();
    bit ok, reached; int g0, a0, d0, g1;
    fill_fb(2); build_model();
    mem_lat = 10;
    g0 = got_q.size(); a0 = addr_q.size(); d0 = done_cnt;
    pulse_start();
    repeat (3) @(posedge clk); #1;
    start = 1'b1; @(posedge clk); #1; start = 1'b0;          // during WAIT
    reached = 0;
    for (int n = 0; n < 5000; n++) begin
      @(negedge clk);
      if (got_q.size() >= g0 + 200) begin reached = 1; break; end
    end
    @(posedge clk); #1; start = 1'b1; @(posedge clk); #1; start = 1'b0;  // during STREAM
    wait_done(20000, ok);
    repeat (30) @(posedge clk); #1;
    checks++; if (!ok || !reached) begin failures++; $display("FAIL ign_timeout got=%0d,%0d exp=1,1", ok, reached); end
    checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL ign_done_count got=%0d exp=1", done_cnt - d0); end
    checks++;
    if (got_q.size() - g0 != NPIX || addr_q.size() - a0 != 4) begin
      failures++; $display("FAIL ign_counts got=%0d,%0d exp=%0d,4", got_q.size() - g0, addr_q.size() - a0, NPIX);
    end
    checks++; if (stream_mis(g0) != 0) begin failures++; $display("FAIL ign_stream got=%0d_mismatches exp=0", stream_mis(g0)); end
    fill_fb(2); build_model();
    g1 = got_q.size();
    run_frame(20000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL second_timeout got=no_done exp=done"); end
    checks++; if (stream_mis(g1) != 0) begin failures++; $display("FAIL second_stream got=%0d_mismatches exp=0", stream_mis(g1)); end
  endtask

  // Test sequence and final report.
  initial begin
    rst_n = 1'b0; start = 1'b0;
    for (int i = 0; i < NB; i++) fb[i] = 8'h00;
    test_reset();
    test_single_pixel();
    test_full_frame();
    test_random_ready();
    test_reset_mid();
    test_start_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
